bch_stim_gen: RTL and testbench

Synthesizable pseudo-random stimulus source for the BCH encode/decode simulation wrapper (`sim`). It produces a random B-bit data word, a random error count in 0..T, and an error pattern of exactly that weight over the (N-K)+B channel bits. It then offers the frame through the `encode_start`/`busy` handshake that `sim` consumes. It replaces the behavioural `$random` stimulus so long BER/regression runs are reproducible from a 32-bit seed and can run on hardware.

---
 rtl/bch_stim_gen.sv | 159 +++++++++++++++
 tb/tb_bch_stim_gen.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_stim_gen.sv
// bch_stim_gen: seed-reproducible LFSR source of data words and bounded-weight error
// patterns for the BCH sim wrapper. Frames are built in shadows and exposed only when complete.
module bch_stim_gen #(
    parameter int          N    = 15,
    parameter int          K    = 5,
    parameter int          T    = 3,
    parameter int          B    = 4,
    parameter logic [31:0] SEED = 32'd1,
    localparam int         E    = N - K,
    localparam int         W    = E + B,
    localparam int         NW   = $clog2(T + 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          busy,
    output logic          encode_start,
    output logic [B-1:0]  data_in,
    output logic [W-1:0]  error,
    output logic [NW-1:0] nerr,
    output logic [31:0]   frame_count,
    output logic [2:0]    dbg_state
);
    localparam logic [31:0] MASK     = 32'h8020_0003;
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam int          NWORDS   = (B + 31) / 32;
    localparam int          PW       = $clog2(W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        NERR  = 3'd2,
        POS   = 3'd3,
        OFFER = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   lfsr_q, lfsr_d, lfsr_step;
    logic [0:0]    word_q, word_d;
    logic [B-1:0]  dsh_q, dsh_d;
    logic [W-1:0]  esh_q, esh_d;
    logic [NW-1:0] csh_q, csh_d;
    logic [NW-1:0] rem_q, rem_d;
    logic [B-1:0]  data_q, data_d;
    logic [W-1:0]  error_q, error_d;
    logic [NW-1:0] nerr_q, nerr_d;
    logic [31:0]   count_q, count_d;
    logic [NW-1:0] draw_cnt;
    logic [PW-1:0] draw_pos;
    logic [W-1:0]  pos_mask;
    logic          accept;

    // Handshake: in OFFER the frame is presented with encode_start = !busy; a rising
    // edge with encode_start high is the acceptance. busy may stall OFFER indefinitely.
    assign encode_start = (state_q == OFFER) && !busy;
    assign data_in      = data_q;
    assign error        = error_q;
    assign nerr         = nerr_q;
    assign frame_count  = count_q;
    assign dbg_state    = state_q;

    always_comb begin
        lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? MASK : 32'h0);
        draw_cnt  = NW'(lfsr_q[30:0] % 31'(T + 1));
        draw_pos  = PW'(lfsr_q[30:0] % 31'(W));
        pos_mask  = W'(1) << draw_pos;
        accept    = (state_q == OFFER) && !busy;

        state_d = state_q;
        lfsr_d  = lfsr_q;
        word_d  = '0;
        dsh_d   = dsh_q;
        esh_d   = esh_q;
        csh_d   = csh_q;
        rem_d   = rem_q;
        data_d  = data_q;
        error_d = error_q;
        nerr_d  = nerr_q;
        count_d = count_q;

        case (state_q)
            IDLE: begin
                if (enable) state_d = DATA;
            end
            DATA: begin
                lfsr_d = lfsr_step;
                // Word i lands in data bits [32i+:32]; bits past B are simply dropped.
                for (int j = 0; j < B; j++) begin
                    if (word_q == 1'(j / 32)) dsh_d[j] = lfsr_q[j % 32];
                end
                if (word_q == 1'(NWORDS - 1)) state_d = NERR;
                else                          word_d  = word_q + 1'b1;
            end
            NERR: begin
                lfsr_d = lfsr_step;
                csh_d  = draw_cnt;
                rem_d  = draw_cnt;
                esh_d  = '0;
                if (draw_cnt == '0) begin
                    data_d  = dsh_q;
                    error_d = '0;
                    nerr_d  = '0;
                    state_d = OFFER;
                end else begin
                    state_d = POS;
                end
            end
            POS: begin
                lfsr_d = lfsr_step;
                // A position already set is a retry: the draw is spent, nothing changes.
                if ((esh_q & pos_mask) == '0) begin
                    esh_d = esh_q | pos_mask;
                    rem_d = rem_q - NW'(1);
                    if (rem_q == NW'(1)) begin
                        data_d  = dsh_q;
                        error_d = esh_q | pos_mask;
                        nerr_d  = csh_q;
                        state_d = OFFER;
                    end
                end
            end
            OFFER: begin
                if (accept) begin
                    count_d = count_q + 32'd1;
                    state_d = enable ? DATA : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_EFF;
            word_q  <= '0;
            dsh_q   <= '0;
            esh_q   <= '0;
            csh_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            error_q <= '0;
            nerr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            word_q  <= word_d;
            dsh_q   <= dsh_d;
            esh_q   <= esh_d;
            csh_q   <= csh_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            error_q <= error_d;
            nerr_q  <= nerr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_bch_stim_gen.sv
// Bench for bch_stim_gen: frame-level LFSR/modulo model feeding an expected-frame queue,
// checked against three instances (SEED=1, SEED=0, SEED=8).
`timescale 1ns/1ps
module tb_bch_stim_gen;
    localparam int N  = 15;
    localparam int K  = 5;
    localparam int T  = 3;
    localparam int B  = 4;
    localparam int W  = (N - K) + B;
    localparam int NW = $clog2(T + 2);
    localparam int FW = B + W + NW;
    localparam logic [31:0] MASK = 32'h8020_0003;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_NERR  = 3'd2;
    localparam logic [2:0] S_POS   = 3'd3;
    localparam logic [2:0] S_OFFER = 3'd4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0, busy = 1'b0, en8 = 1'b0, busy8 = 1'b0;

    logic es1, es0, es8;
    logic [B-1:0] d1, d0, d8;
    logic [W-1:0] e1, e0, e8;
    logic [NW-1:0] n1, n0, n8;
    logic [31:0] fc1, fc0, fc8;
    logic [2:0] st1, st0, st8;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_r;
    logic [FW-1:0] exp_q[$];

    always #5 clk = ~clk;

    bch_stim_gen #(.N(N), .K(K), .T(T), .B(B), .SEED(32'd1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .busy(busy),
        .encode_start(es1), .data_in(d1), .error(e1), .nerr(n1),
        .frame_count(fc1), .dbg_state(st1));

    bch_stim_gen #(.N(N), .K(K), .T(T), .B(B), .SEED(32'd0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .busy(busy),
        .encode_start(es0), .data_in(d0), .error(e0), .nerr(n0),
        .frame_count(fc0), .dbg_state(st0));

    bch_stim_gen #(.N(N), .K(K), .T(T), .B(B), .SEED(32'd8)) dut8 (
        .clk(clk), .reset(reset), .enable(en8), .busy(busy8),
        .encode_start(es8), .data_in(d8), .error(e8), .nerr(n8),
        .frame_count(fc8), .dbg_state(st8));

    function automatic logic [31:0] adv(input logic [31:0] r);
        return {1'b0, r[31:1]} ^ (r[0] ? MASK : 32'h0);
    endfunction

    // Frame = {data, pattern, count}; draws = LFSR advances spent building it.
    task automatic model_frame(input logic [31:0] r_in, output logic [31:0] r_out,
                               output logic [FW-1:0] frame, output int draws);
        logic [31:0] r;
        logic [B-1:0] d;
        logic [W-1:0] pat;
        int c, rem, p;
        r = r_in;
        d = r[B-1:0];
        r = adv(r);
        c = int'(r[30:0] % 31'(T + 1));
        r = adv(r);
        pat = '0;
        rem = c;
        draws = 2;
        while (rem > 0) begin
            p = int'(r[30:0] % 31'(W));
            r = adv(r);
            draws++;
            if (!pat[p]) begin
                pat[p] = 1'b1;
                rem--;
            end
        end
        frame = {d, pat, NW'(c)};
        r_out = r;
    endtask

    task automatic next_expected(output int draws);
        logic [FW-1:0] f;
        model_frame(m_r, m_r, f, draws);
        exp_q.push_back(f);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b0;
        busy = 1'b0;
        en8 = 1'b0;
        busy8 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        m_r = 32'd1;
        exp_q.delete();
    endtask

    // Runs from IDLE; encode_start is predicted cycle by cycle from the model draw counts.
    task automatic run_frames(input int total, input bit rand_busy, input string tag);
        int n, offer, accepted, draws;
        logic es_exp;
        logic [FW-1:0] exp_f;
        accepted = 0;
        next_expected(draws);
        enable = 1'b1;
        n = 1;
        offer = 1 + draws;
        while (accepted < total && n < total * 12 + 200) begin
            busy = rand_busy && ($urandom_range(0, 15) == 0);
            #1;
            es_exp = (n > offer) && !busy;
            checks++;
            if (es1 !== es_exp || es0 !== es_exp) begin
                errors++;
                $display("FAIL %s encode_start edge %0d: got %b/%b expected %b", tag, n, es1, es0, es_exp);
            end
            if (es_exp) begin
                exp_f = exp_q.pop_front();
                checks++;
                if ({d1, e1, n1} !== exp_f || {d0, e0, n0} !== exp_f) begin
                    errors++;
                    $display("FAIL %s frame %0d: got %h/%h expected %h", tag, accepted, {d1, e1, n1}, {d0, e0, n0}, exp_f);
                end
                checks++;
                if ($countones(e1) != int'(n1) || int'(n1) > T) begin
                    errors++;
                    $display("FAIL %s weight frame %0d: popcount %0d nerr %0d limit %0d", tag, accepted, $countones(e1), n1, T);
                end
                accepted++;
                if (accepted == total) enable = 1'b0;
                else begin
                    next_expected(draws);
                    offer = n + draws;
                end
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (accepted != total) begin
            errors++;
            $display("FAIL %s timeout: accepted %0d expected %0d", tag, accepted, total);
        end
        checks++;
        if (fc1 !== 32'(total) || fc0 !== 32'(total) || st1 !== S_IDLE) begin
            errors++;
            $display("FAIL %s final count: got %0d/%0d state %0d expected %0d state %0d", tag, fc1, fc0, st1, total, S_IDLE);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            enable = 1'($urandom_range(0, 1));
            busy = 1'($urandom_range(0, 1));
            en8 = 1'($urandom_range(0, 1));
            busy8 = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({es1, d1, e1, n1, fc1, st1, es0, fc0, st0, es8, fc8, st8} !== '0) begin
                errors++;
                $display("FAIL reset_values cycle %0d: es %b data %h err %h nerr %0d count %0d state %0d expected all 0",
                         i, es1, d1, e1, n1, fc1, st1);
            end
        end
        enable = 1'b0;
        busy = 1'b0;
        en8 = 1'b0;
        busy8 = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (es1 !== 1'b0 || st1 !== S_IDLE || fc1 !== 32'd0) begin
                errors++;
                $display("FAIL idle_after_reset cycle %0d: es %b state %0d count %0d expected 0 %0d 0", i, es1, st1, fc1, S_IDLE);
            end
        end
    endtask

    // Follows test_reset with no fresh reset, so the first frame also shows the idle
    // cycles left the LFSR untouched.
    task automatic test_seed_zero();
        m_r = 32'd1;
        exp_q.delete();
        run_frames(20, 1'b0, "seed0_vs_seed1");
    endtask

    task automatic test_zero_errors();
        logic [31:0] r;
        logic [FW-1:0] exp_f;
        int draws;
        do_reset();
        // Seed 8 yields an error count of 0 on its first frame.
        model_frame(32'd8, r, exp_f, draws);
        en8 = 1'b1;
        @(negedge clk);
        checks++;
        if (es8 !== 1'b0) begin
            errors++;
            $display("FAIL zero_err edge1 encode_start: got %b expected 0", es8);
        end
        @(negedge clk);
        checks++;
        if (es8 !== 1'b0) begin
            errors++;
            $display("FAIL zero_err edge2 encode_start: got %b expected 0", es8);
        end
        @(negedge clk);
        en8 = 1'b0;
        checks++;
        if (es8 !== 1'b1) begin
            errors++;
            $display("FAIL zero_err edge3 encode_start: got %b expected 1", es8);
        end
        checks++;
        if ({d8, e8, n8} !== exp_f || e8 !== '0 || n8 !== '0) begin
            errors++;
            $display("FAIL zero_err frame: got %h expected %h", {d8, e8, n8}, exp_f);
        end
        @(negedge clk);
        checks++;
        if (fc8 !== 32'd1 || es8 !== 1'b0 || st8 !== S_IDLE) begin
            errors++;
            $display("FAIL zero_err after_accept: count %0d es %b state %0d expected 1 0 %0d", fc8, es8, st8, S_IDLE);
        end
    endtask

    task automatic test_busy_stall();
        int draws, k, bad;
        logic [FW-1:0] exp_f;
        do_reset();
        next_expected(draws);
        enable = 1'b1;
        busy = 1'b1;
        k = 0;
        while (st1 !== S_OFFER && k < 100) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        checks++;
        if (k != draws + 1) begin
            errors++;
            $display("FAIL stall latency: got %0d cycles expected %0d", k, draws + 1);
        end
        exp_f = exp_q.pop_front();
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (es1 !== 1'b0 || {d1, e1, n1} !== exp_f || fc1 !== 32'd0 || st1 !== S_OFFER) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall hold: %0d bad cycles expected 0 (frame %h expected %h)", bad, {d1, e1, n1}, exp_f);
        end
        busy = 1'b0;
        #1;
        checks++;
        if (es1 !== 1'b1) begin
            errors++;
            $display("FAIL stall release encode_start: got %b expected 1", es1);
        end
        @(negedge clk);
        checks++;
        if (es1 !== 1'b0 || fc1 !== 32'd1 || st1 !== S_IDLE) begin
            errors++;
            $display("FAIL stall accept: es %b count %0d state %0d expected 0 1 %0d", es1, fc1, st1, S_IDLE);
        end
        // The stall must not have advanced the LFSR: frame 2 continues the model sequence.
        next_expected(draws);
        enable = 1'b1;
        k = 0;
        while (es1 !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        exp_f = exp_q.pop_front();
        checks++;
        if (k != draws + 1 || {d1, e1, n1} !== exp_f) begin
            errors++;
            $display("FAIL stall next_frame: got %h after %0d expected %h after %0d", {d1, e1, n1}, k, exp_f, draws + 1);
        end
        @(negedge clk);
        checks++;
        if (fc1 !== 32'd2) begin
            errors++;
            $display("FAIL stall count: got %0d expected 2", fc1);
        end
    endtask

    task automatic test_enable_drop_and_abort();
        int draws, k;
        logic [FW-1:0] exp_f, f2;
        logic [31:0] r_tmp;
        logic exp_pos;
        logic [2:0] abort_state;
        do_reset();
        next_expected(draws);
        exp_pos = (exp_q[0][NW-1:0] != '0);
        enable = 1'b1;
        k = 0;
        while (st1 !== S_POS && k < 4) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        checks++;
        if ((st1 === S_POS) !== exp_pos) begin
            errors++;
            $display("FAIL drop reach_pos: state %0d, POS expected %b", st1, exp_pos);
        end
        k = 0;
        while (es1 !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        exp_f = exp_q.pop_front();
        checks++;
        if (es1 !== 1'b1 || {d1, e1, n1} !== exp_f) begin
            errors++;
            $display("FAIL drop frame: es %b frame %h expected 1 %h", es1, {d1, e1, n1}, exp_f);
        end
        @(negedge clk);
        checks++;
        if (fc1 !== 32'd1 || st1 !== S_IDLE) begin
            errors++;
            $display("FAIL drop after_accept: count %0d state %0d expected 1 %0d", fc1, st1, S_IDLE);
        end
        // Abort frame 2 part-way through its generation.
        model_frame(m_r, r_tmp, f2, draws);
        abort_state = (f2[NW-1:0] != '0) ? S_POS : S_NERR;
        enable = 1'b1;
        k = 0;
        while (st1 !== abort_state && k < 4) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (st1 !== abort_state || fc1 !== 32'd1 || es1 !== 1'b0) begin
            errors++;
            $display("FAIL abort pre_reset: state %0d count %0d es %b expected %0d 1 0", st1, fc1, es1, abort_state);
        end
        reset = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (fc1 !== 32'd0 || st1 !== S_IDLE || es1 !== 1'b0) begin
            errors++;
            $display("FAIL abort in_reset: count %0d state %0d es %b expected 0 %0d 0", fc1, st1, es1, S_IDLE);
        end
        reset = 1'b1;
        @(negedge clk);
        m_r = 32'd1;
        exp_q.delete();
        next_expected(draws);
        enable = 1'b1;
        k = 0;
        while (es1 !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        exp_f = exp_q.pop_front();
        checks++;
        if (k != draws + 1 || {d1, e1, n1} !== exp_f) begin
            errors++;
            $display("FAIL abort restart_frame: got %h after %0d expected %h after %0d", {d1, e1, n1}, k, exp_f, draws + 1);
        end
        @(negedge clk);
        checks++;
        if (fc1 !== 32'd1) begin
            errors++;
            $display("FAIL abort restart_count: got %0d expected 1", fc1);
        end
    endtask

    task automatic test_long_run();
        do_reset();
        run_frames(10000, 1'b1, "long_run");
    endtask

    initial begin
        test_reset();
        test_seed_zero();
        test_zero_errors();
        test_busy_stall();
        test_enable_drop_and_abort();
        test_long_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
